rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux.sv | 134 +++++++++++++
 tb/tb_rr_arb_mux.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// Registered M-to-1 channel multiplexer with fixed-select or round-robin arbitration.
// Optional build macro RR_ARB_MUX_XFER_CNT_EN adds a saturating 16-bit transfer counter output.
module rr_arb_mux #(
   parameter int N = 8,
   parameter int M = 4,
   localparam int SELW = $clog2(M)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [M*N-1:0]    in_data,
   input  logic [M-1:0]      in_valid,
   output logic [M-1:0]      in_ready,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   output logic [N-1:0]      out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SELW-1:0]   out_ch
`ifdef RR_ARB_MUX_XFER_CNT_EN
   ,
   output logic [15:0]       xfer_cnt
`endif
);

   // Valid/ready: a word moves across an interface on a rising edge where valid and
   // ready are both high; valid never depends on ready, and a held word stays stable.
   logic [N-1:0]    out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic [SELW-1:0] out_ch_q, out_ch_d;
   logic [SELW-1:0] ptr_q, ptr_d;

   logic            load;
   logic            grant_valid;
   logic [SELW-1:0] grant;
   logic [N-1:0]    grant_data;
   logic            xfer;
   int              rr_idx;

   // Reset gates the load path so nothing is offered upstream while rst is high.
   assign load = (~out_valid_q | out_ready) & ~rst;

   always_comb begin : grant_search
      grant_valid = 1'b0;
      grant       = '0;
      rr_idx      = 0;
      if (!mode) begin
         for (int i = 0; i < M; i++) begin
            if ((SELW'(i) == sel) && in_valid[i]) begin
               grant_valid = 1'b1;
               grant       = SELW'(i);
            end
         end
      end else begin
         for (int k = 0; k < M; k++) begin
            rr_idx = int'(ptr_q) + k;
            if (rr_idx >= M) begin
               rr_idx = rr_idx - M;
            end
            if (!grant_valid && in_valid[rr_idx]) begin
               grant_valid = 1'b1;
               grant       = SELW'(rr_idx);
            end
         end
      end
   end

   assign grant_data = in_data[int'(grant)*N +: N];
   assign xfer       = load & grant_valid;

   always_comb begin : ready_decode
      in_ready = '0;
      if (xfer) begin
         in_ready[grant] = 1'b1;
      end
   end

   always_comb begin : next_state
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load) begin
         out_valid_d = grant_valid;
      end
      if (xfer) begin
         out_data_d = grant_data;
         out_ch_d   = grant;
         // Pointer advances only on round-robin transfers; explicit wrap covers non-power-of-two M.
         if (mode) begin
            ptr_d = (grant == SELW'(M - 1)) ? '0 : grant + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;

`ifdef RR_ARB_MUX_XFER_CNT_EN
   logic [15:0] xfer_cnt_q, xfer_cnt_d;

   always_comb begin : cnt_next
      xfer_cnt_d = xfer_cnt_q;
      if (xfer && (xfer_cnt_q != 16'hFFFF)) begin
         xfer_cnt_d = xfer_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_cnt_q <= '0;
      end else begin
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: an M=4 and an M=3 instance, scenario tasks plus an output scoreboard.
// Define RR_ARB_MUX_XFER_CNT_EN to also exercise the transfer counter.
module tb_rr_arb_mux;
   localparam int N = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst4, rst3;
   logic [31:0] in_data4;
   logic [3:0]  in_valid4, in_ready4;
   logic        mode4, out_valid4, out_ready4;
   logic [1:0]  sel4, out_ch4;
   logic [7:0]  out_data4;
   logic [23:0] in_data3;
   logic [2:0]  in_valid3, in_ready3;
   logic        mode3, out_valid3, out_ready3;
   logic [1:0]  sel3, out_ch3;
   logic [7:0]  out_data3;
`ifdef RR_ARB_MUX_XFER_CNT_EN
   logic [15:0] xfer_cnt4, xfer_cnt3;
`endif

   int         tests_run = 0;
   int         tests_failed = 0;
   bit         sb_off = 1'b0;
   logic [9:0] exp4_q[$];
   logic [9:0] exp3_q[$];

   rr_arb_mux #(.N(N), .M(4)) dut4 (
      .clk(clk), .rst(rst4), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
      .mode(mode4), .sel(sel4), .out_data(out_data4), .out_valid(out_valid4),
      .out_ready(out_ready4), .out_ch(out_ch4)
`ifdef RR_ARB_MUX_XFER_CNT_EN
      , .xfer_cnt(xfer_cnt4)
`endif
   );

   rr_arb_mux #(.N(N), .M(3)) dut3 (
      .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .mode(mode3), .sel(sel3), .out_data(out_data3), .out_valid(out_valid3),
      .out_ready(out_ready3), .out_ch(out_ch3)
`ifdef RR_ARB_MUX_XFER_CNT_EN
      , .xfer_cnt(xfer_cnt3)
`endif
   );

   // Scoreboards: every accepted output word is matched against the oldest expectation.
   always @(negedge clk) begin
      logic [9:0] e;
      if (!sb_off && rst4 === 1'b0 && out_valid4 === 1'b1 && out_ready4 === 1'b1) begin
         tests_run++;
         if (exp4_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb4_unexpected: got ch=%0d data=%h, required no word", out_ch4, out_data4);
         end else begin
            e = exp4_q.pop_front();
            if ({out_ch4, out_data4} !== e) begin
               tests_failed++;
               $display("FAIL sb4_word: got ch=%0d data=%h, required ch=%0d data=%h",
                        out_ch4, out_data4, e[9:8], e[7:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [9:0] e;
      if (rst3 === 1'b0 && out_valid3 === 1'b1 && out_ready3 === 1'b1) begin
         tests_run++;
         if (exp3_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb3_unexpected: got ch=%0d data=%h, required no word", out_ch3, out_data3);
         end else begin
            e = exp3_q.pop_front();
            if ({out_ch3, out_data3} !== e) begin
               tests_failed++;
               $display("FAIL sb3_word: got ch=%0d data=%h, required ch=%0d data=%h",
                        out_ch3, out_data3, e[9:8], e[7:0]);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_valid4 = 4'hF; mode4 = 1'b1; out_ready4 = 1'b1;
      in_valid3 = 3'b111; mode3 = 1'b1; out_ready3 = 1'b1;
      repeat (2) cyc();
      @(negedge clk);
      tests_run++;
      if (in_ready4 !== 4'b0000) begin
         tests_failed++; $display("FAIL rst_in_ready4: got %b, required 0000", in_ready4);
      end
      tests_run++;
      if ({out_valid4, out_data4, out_ch4} !== 11'd0) begin
         tests_failed++;
         $display("FAIL rst_out4: got v=%b d=%h ch=%0d, required all 0", out_valid4, out_data4, out_ch4);
      end
      tests_run++;
      if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_dut3: got in_ready=%b v=%b, required 000 0", in_ready3, out_valid3);
      end
      cyc();
      in_valid4 = '0; in_valid3 = '0;
      rst4 = 1'b0; rst3 = 1'b0;
      cyc();
   endtask

   task automatic test_fixed();
      mode4 = 1'b0; sel4 = 2'd2; in_data4 = 32'h0; in_data4[23:16] = 8'hA5;
      in_valid4 = 4'b0100; out_ready4 = 1'b1;
      exp4_q.push_back({2'd2, 8'hA5});
      @(negedge clk);
      tests_run++;
      if (in_ready4 !== 4'b0100) begin
         tests_failed++; $display("FAIL fixed_in_ready: got %b, required 0100", in_ready4);
      end
      cyc();
      in_valid4 = '0;
      @(negedge clk);
      tests_run++;
      if (out_valid4 !== 1'b1 || out_data4 !== 8'hA5 || out_ch4 !== 2'd2) begin
         tests_failed++;
         $display("FAIL fixed_out: got v=%b d=%h ch=%0d, required 1 a5 2", out_valid4, out_data4, out_ch4);
      end
      cyc();
      @(negedge clk);
      tests_run++;
      if (out_valid4 !== 1'b0 || out_data4 !== 8'hA5 || out_ch4 !== 2'd2) begin
         tests_failed++;
         $display("FAIL fixed_idle: got v=%b d=%h ch=%0d, required 0 a5 2", out_valid4, out_data4, out_ch4);
      end
      cyc();
   endtask

   task automatic test_rr_sequence();
      logic [1:0] ch, prev;
      logic [7:0] d;
      prev = 2'd0;
      mode4 = 1'b1; in_valid4 = 4'hF; out_ready4 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         ch = 2'(k % 4);
         in_data4 = $urandom();
         d = in_data4[ch*8 +: 8];
         exp4_q.push_back({ch, d});
         @(negedge clk);
         tests_run++;
         if (in_ready4 !== (4'b0001 << ch)) begin
            tests_failed++;
            $display("FAIL rr_in_ready[%0d]: got %b, required %b", k, in_ready4, 4'b0001 << ch);
         end
         if (k > 0) begin
            tests_run++;
            if (out_valid4 !== 1'b1 || out_ch4 !== prev) begin
               tests_failed++;
               $display("FAIL rr_no_bubble[%0d]: got v=%b ch=%0d, required 1 %0d", k, out_valid4, out_ch4, prev);
            end
         end
         prev = ch;
         cyc();
      end
      in_valid4 = '0;
      @(negedge clk);
      tests_run++;
      if (out_valid4 !== 1'b1 || out_ch4 !== 2'd0) begin
         tests_failed++;
         $display("FAIL rr_last: got v=%b ch=%0d, required 1 0", out_valid4, out_ch4);
      end
      repeat (2) cyc();
   endtask

   task automatic test_ptr_hold();
      logic [7:0] d;
      mode4 = 1'b0; sel4 = 2'd3; in_valid4 = 4'b1000;
      in_data4 = $urandom(); d = in_data4[31:24];
      exp4_q.push_back({2'd3, d});
      @(negedge clk);
      tests_run++;
      if (in_ready4 !== 4'b1000) begin
         tests_failed++; $display("FAIL hold_fixed_ready: got %b, required 1000", in_ready4);
      end
      cyc();
      in_valid4 = '0;
      repeat (2) cyc();
      // Round-robin pointer was left at 1 and must survive the fixed-mode transfer.
      mode4 = 1'b1; in_valid4 = 4'hF;
      in_data4 = $urandom(); d = in_data4[15:8];
      exp4_q.push_back({2'd1, d});
      @(negedge clk);
      tests_run++;
      if (in_ready4 !== 4'b0010) begin
         tests_failed++; $display("FAIL hold_rr_ready: got %b, required 0010", in_ready4);
      end
      cyc();
      in_valid4 = '0;
      repeat (2) cyc();
   endtask

   task automatic test_backpressure();
      logic [7:0] d1, d2;
      mode4 = 1'b0; sel4 = 2'd1; in_valid4 = 4'b0010; out_ready4 = 1'b1;
      in_data4 = $urandom(); d1 = in_data4[15:8];
      exp4_q.push_back({2'd1, d1});
      cyc();
      out_ready4 = 1'b0;
      d2 = 8'($urandom_range(0, 255));
      in_data4[15:8] = d2;
      mode4 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests_run++;
         if (out_valid4 !== 1'b1 || out_data4 !== d1 || out_ch4 !== 2'd1 || in_ready4 !== 4'b0000) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d rdy=%b, required 1 %h 1 0000",
                     k, out_valid4, out_data4, out_ch4, in_ready4, d1);
         end
         cyc();
      end
      mode4 = 1'b0;
      out_ready4 = 1'b1;
      exp4_q.push_back({2'd1, d2});
      @(negedge clk);
      tests_run++;
      if (in_ready4 !== 4'b0010) begin
         tests_failed++; $display("FAIL bp_release_ready: got %b, required 0010", in_ready4);
      end
      cyc();
      in_valid4 = '0;
      @(negedge clk);
      tests_run++;
      if (out_valid4 !== 1'b1 || out_data4 !== d2) begin
         tests_failed++;
         $display("FAIL bp_next_word: got v=%b d=%h, required 1 %h", out_valid4, out_data4, d2);
      end
      repeat (2) cyc();
   endtask

   task automatic test_rr_wrap3();
      logic [1:0] ch;
      logic [7:0] d;
      mode3 = 1'b1; in_valid3 = 3'b101; out_ready3 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ch = (k % 2 == 1) ? 2'd2 : 2'd0;
         in_data3 = 24'($urandom());
         d = in_data3[ch*8 +: 8];
         exp3_q.push_back({ch, d});
         @(negedge clk);
         tests_run++;
         if (in_ready3 !== (3'b001 << ch)) begin
            tests_failed++;
            $display("FAIL wrap3_ready[%0d]: got %b, required %b", k, in_ready3, 3'b001 << ch);
         end
         cyc();
      end
      in_valid3 = '0;
      repeat (2) cyc();
   endtask

   task automatic test_invalid_sel3();
      logic [7:0] d;
      mode3 = 1'b0; sel3 = 2'd1; in_valid3 = 3'b111; out_ready3 = 1'b1;
      in_data3 = 24'($urandom()); d = in_data3[15:8];
      exp3_q.push_back({2'd1, d});
      cyc();
      sel3 = 2'd3;
      @(negedge clk);
      tests_run++;
      if (in_ready3 !== 3'b000) begin
         tests_failed++; $display("FAIL badsel_ready: got %b, required 000", in_ready3);
      end
      cyc();
      @(negedge clk);
      tests_run++;
      if (out_valid3 !== 1'b0 || out_data3 !== d || out_ch3 !== 2'd1) begin
         tests_failed++;
         $display("FAIL badsel_out: got v=%b d=%h ch=%0d, required 0 %h 1", out_valid3, out_data3, out_ch3, d);
      end
      cyc();
      sel3 = 2'd2; out_ready3 = 1'b0; in_data3 = 24'($urandom()); in_valid3 = 3'b100;
      cyc();
      mode3 = 1'b1; in_valid3 = 3'b111;
      @(negedge clk);
      tests_run++;
      if (out_valid3 !== 1'b1 || out_ch3 !== 2'd2) begin
         tests_failed++; $display("FAIL held_pre_rst: got v=%b ch=%0d, required 1 2", out_valid3, out_ch3);
      end
      cyc();
      rst3 = 1'b1;
      cyc();
      @(negedge clk);
      tests_run++;
      if (out_valid3 !== 1'b0 || out_data3 !== 8'h00 || out_ch3 !== 2'd0 || in_ready3 !== 3'b000) begin
         tests_failed++;
         $display("FAIL mid_rst: got v=%b d=%h ch=%0d rdy=%b, required 0 00 0 000",
                  out_valid3, out_data3, out_ch3, in_ready3);
      end
      cyc();
      in_valid3 = '0; rst3 = 1'b0; out_ready3 = 1'b1;
      repeat (2) cyc();
   endtask

`ifdef RR_ARB_MUX_XFER_CNT_EN
   task automatic test_xfer_cnt();
      logic [1:0] ch;
      rst4 = 1'b1; in_valid4 = '0;
      cyc();
      rst4 = 1'b0;
      @(negedge clk);
      tests_run++;
      if (xfer_cnt4 !== 16'd0) begin
         tests_failed++; $display("FAIL cnt_reset: got %0d, required 0", xfer_cnt4);
      end
      cyc();
      mode4 = 1'b1; out_ready4 = 1'b1; in_valid4 = 4'hF; in_data4 = 32'h44332211;
      for (int k = 0; k < 5; k++) begin
         ch = 2'(k % 4);
         exp4_q.push_back({ch, in_data4[ch*8 +: 8]});
         cyc();
      end
      in_valid4 = '0;
      @(negedge clk);
      tests_run++;
      if (xfer_cnt4 !== 16'd5) begin
         tests_failed++; $display("FAIL cnt_five: got %0d, required 5", xfer_cnt4);
      end
      repeat (2) cyc();
      sb_off = 1'b1;
      in_valid4 = 4'hF;
      repeat (65535) cyc();
      in_valid4 = '0;
      repeat (2) cyc();
      sb_off = 1'b0;
      @(negedge clk);
      tests_run++;
      if (xfer_cnt4 !== 16'hFFFF) begin
         tests_failed++; $display("FAIL cnt_saturate: got %h, required ffff", xfer_cnt4);
      end
      cyc();
   endtask
`endif

   initial begin
      rst4 = 1'b1; rst3 = 1'b1;
      in_data4 = '0; in_valid4 = '0; mode4 = 1'b0; sel4 = '0; out_ready4 = 1'b0;
      in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b0;
      #1;
      test_reset();
      test_fixed();
      test_rr_sequence();
      test_ptr_hold();
      test_backpressure();
      test_rr_wrap3();
      test_invalid_sel3();
`ifdef RR_ARB_MUX_XFER_CNT_EN
      test_xfer_cnt();
`endif
      tests_run++;
      if (exp4_q.size() != 0 || exp3_q.size() != 0) begin
         tests_failed++;
         $display("FAIL sb_drain: got %0d/%0d words pending, required 0/0", exp4_q.size(), exp3_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
